// File: rtl/priority_enc_arb.sv
// rtl/priority_enc_arb.sv - registered priority arbiter with sticky pending bits and valid/ack handshake
// Optional round-robin priority when PRIO_RR_EN is defined; fixed priority (WIDTH-1 highest) otherwise.
module priority_enc_arb #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] mask,
  input  logic             ack,
  output logic [IDXW-1:0]  out,
  output logic             valid,
  output logic [WIDTH-1:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  out_q, out_d;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] clr;
  logic [IDXW-1:0]  win_idx;
  logic             win_found;
  logic             ack_fire;

  assign eligible = pending_q & mask;
  assign ack_fire = (state_q == PRESENT) && ack;

  always_comb begin
    clr = '0;
    if (ack_fire) clr[out_q] = 1'b1;
  end

`ifdef PRIO_RR_EN
  logic [IDXW-1:0] ptr_q;

  // Search descends from the pointer and wraps from 0 back to WIDTH-1.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      idx = (int'(ptr_q) >= j) ? (int'(ptr_q) - j) : (int'(ptr_q) + WIDTH - j);
      if (!win_found && eligible[idx]) begin
        win_idx   = IDXW'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDXW'(WIDTH - 1);
    end else if (ack_fire) begin
      ptr_q <= (out_q == '0) ? IDXW'(WIDTH - 1) : (out_q - 1'b1);
    end
  end
`else
  // Ascending scan: the last eligible index seen is the highest, which wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eligible[i]) begin
        win_idx   = IDXW'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          out_d   = win_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // No preemption: out is frozen until the consumer acks.
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      pending_q <= (pending_q & ~clr) | req;
    end
  end

  assign out     = out_q;
  assign valid   = (state_q == PRESENT);
  assign pending = pending_q;

endmodule

// File: tb/tb_priority_enc_arb.sv
// tb/tb_priority_enc_arb.sv - directed self-checking bench for priority_enc_arb (WIDTH=8)
module tb_priority_enc_arb;

  localparam int WIDTH = 8;
  localparam int IDXW  = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [IDXW-1:0]  out;
  logic             valid;
  logic [WIDTH-1:0] pending;

  int tests = 0;
  int fails = 0;

  priority_enc_arb #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .out     (out),
    .valid   (valid),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for valid, then check the presented index.
  task automatic expect_grant(input string tag, input int exp_idx);
    for (int n = 0; n < 8 && valid !== 1'b1; n++) step();
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk({tag, "_out"}, 64'(out), 64'(exp_idx));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int exp_rr [4];

  initial begin
    rst  = 1'b1;
    req  = '0;
    mask = 8'hFF;
    ack  = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    rst = 1'b0;

    // Test 1: pulse 0010_1100, latency and grant order 5,3,2.
    req = 8'b0010_1100;
    step();
    req = '0;
    chk("t1_pend", 64'(pending), 64'h2C);
    chk("t1_lat_v0", 64'(valid), 64'd0);
    step();
    chk("t1_lat_v1", 64'(valid), 64'd1);
    chk("t1_g5", 64'(out), 64'd5);
    do_ack();
    chk("t1_ackdrop", 64'(valid), 64'd0);
    chk("t1_pend2", 64'(pending), 64'h0C);
    step();
    chk("t1_g3_spacing", 64'(valid), 64'd1);
    expect_grant("t1_g3", 3);
    do_ack();
    expect_grant("t1_g2", 2);
    do_ack();
    step();
    chk("t1_end_valid", 64'(valid), 64'd0);
    chk("t1_end_pend", 64'(pending), 64'h00);

    // Test 2: mask 0F with F1 -> 0, then unmask -> 7,6,5,4.
    mask = 8'h0F;
    req  = 8'hF1;
    step();
    req = '0;
    expect_grant("t2_g0", 0);
    mask = 8'hFF;
    do_ack();
    expect_grant("t2_g7", 7);
    do_ack();
    expect_grant("t2_g6", 6);
    do_ack();
    expect_grant("t2_g5", 5);
    do_ack();
    expect_grant("t2_g4", 4);
    // Test 3: higher-priority arrival while presenting 4 does not preempt.
    req = 8'h80;
    step();
    req = '0;
    step();
    step();
    chk("t3_hold_valid", 64'(valid), 64'd1);
    chk("t3_hold_out", 64'(out), 64'd4);
    chk("t3_pend", 64'(pending), 64'h90);
    mask = 8'hEF;
    step();
    chk("t3_mask_hold", 64'(out), 64'd4);
    mask = 8'hFF;
    do_ack();
    expect_grant("t3_g7", 7);
    do_ack();
    step();
    chk("t3_empty", 64'(pending), 64'h00);

    // Test 4: req[3] held; set wins over clear on the ack edge.
    req = 8'h08;
    step();
    expect_grant("t4_g3a", 3);
    do_ack();
    chk("t4_sticky", 64'(pending[3]), 64'd1);
    chk("t4_v0", 64'(valid), 64'd0);
    step();
    chk("t4_regrant_v", 64'(valid), 64'd1);
    chk("t4_regrant_o", 64'(out), 64'd3);
    req = '0;
    do_ack();
    chk("t4_cleared", 64'(pending), 64'h00);

    // ack in IDLE is ignored.
    ack = 1'b1;
    step();
    step();
    chk("idle_ack_v", 64'(valid), 64'd0);
    chk("idle_ack_p", 64'(pending), 64'h00);
    ack = 1'b0;

    // Test 5: req 81 held from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef PRIO_RR_EN
    exp_rr = '{7, 0, 7, 0};
`else
    exp_rr = '{7, 7, 7, 7};
`endif
    req = 8'h81;
    for (int k = 0; k < 4; k++) begin
      expect_grant($sformatf("t5_g%0d", k), exp_rr[k]);
      do_ack();
    end
    req = '0;

    // Test 6: reset mid-grant discards everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'h1C;
    step();
    req = '0;
    expect_grant("t6_g4", 4);
    chk("t6_pend", 64'(pending), 64'h1C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(valid), 64'd0);
    chk("t6_rst_out", 64'(out), 64'd0);
    chk("t6_rst_pend", 64'(pending), 64'h00);
    step();
    step();
    step();
    chk("t6_no_grant", 64'(valid), 64'd0);

    // Requests in the reset cycle are dropped.
    rst = 1'b1;
    req = 8'h40;
    step();
    rst = 1'b0;
    req = '0;
    chk("rst_req_drop", 64'(pending), 64'h00);
    step();
    chk("rst_req_nov", 64'(valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/priority_enc_arb.md
# priority_enc_arb

Parametrised, registered successor to the 4-bit priority encoder. It collects request lines into a sticky pending register and presents the highest-priority enabled request as a binary index with a valid/ack handshake. The acknowledged request is then cleared. It serves as the interrupt/request arbiter in front of shared-resource controllers in the same design family. Optionally, priority rotates round-robin after each grant.

## Interface
- WIDTH, 8, number of request lines; legal range 2..64, non-power-of-2 allowed.
- IDXW (localparam), $clog2(WIDTH), width of the index output.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  WIDTH  level request bits; a high bit is sampled into pending every cycle.
- mask  input  WIDTH  1 = line eligible for grant; 0 = line held pending but not granted.
- ack  input  1  consumer accepts the presented index; meaningful only while valid=1.
- out  output  IDXW  registered index of the presented request.
- valid  output  1  out holds a live grant.
- pending  output  WIDTH  registered pending bits, for debug/status.

## Operation
- Pending update: pending <= (pending & ~clr) | req.
  - clr is one-hot(out) when valid & ack, else 0.
  - Set wins over clear: if req[k] is high in the same cycle that index k is acked, pending[k] stays 1.
- Eligible set is pending & mask.
- Fixed priority (default): index WIDTH-1 is highest, index 0 is lowest, matching the 4-bit encoder.
- FSM has two states, IDLE and PRESENT.
  - IDLE: if eligible is nonzero, load out with the winning index, set valid=1, go to PRESENT. Otherwise valid=0 and out holds its previous value.
  - PRESENT: out and valid are held stable. No preemption: a higher-priority arrival, or masking the presented bit, does not change out.
  - PRESENT with ack=1: clear that pending bit, set valid=0 next cycle, return to IDLE.
- ack while in IDLE is ignored.
- Reset: pending=0, out=0, valid=0, state=IDLE, rotation pointer=WIDTH-1.
  - Reset mid-grant discards the grant and all pending bits, with no ack needed.
  - Requests present in the reset cycle are dropped.

## Timing
- req high at edge t → pending bit set after edge t → earliest valid=1 after edge t+1. Request-to-grant latency is 2 cycles.
- Ack sampled at edge t → valid=0 after edge t. The next grant is evaluated in IDLE, so it appears after edge t+1.
- Minimum grant spacing is 2 cycles. Sustained throughput is 1 grant per 2 cycles.
- Grant selection is based on pending/mask values registered at the edge that leaves IDLE.
- out is valid only while valid=1. The consumer must not use out when valid=0.

## Configuration
- PRIO_RR_EN defined: round-robin priority.
  - After ack of index k, the pointer becomes k-1, wrapping to WIDTH-1 when k=0.
  - The search starts at the pointer index and descends, wrapping from 0 to WIDTH-1.
  - The pointer resets to WIDTH-1, so the first grant after reset matches fixed priority.
- PRIO_RR_EN undefined: fixed priority as above. No pointer register is synthesised. Ports and handshake are identical in both builds.

## Test plan
- WIDTH=8, mask=8'hFF, one-cycle pulse req=8'b0010_1100, ack asserted each time valid=1 → grants out=5, 3, 2 in order, each valid 1 cycle after its ack-return; then valid=0, pending=0.
- mask=8'h0F, req pulse 8'hF1 → out=0. Then mask=8'hFF after the ack → out=7, 6, 5, 4 granted in sequence.
- Presented out=4 with ack held low; req pulse 8'h80 arrives → out stays 4, valid stays 1. After ack → next grant out=7.
- req[3] held high continuously, ack in PRESENT → pending[3] stays 1. Index 3 is re-granted 2 cycles after the ack.
- req held at 8'h81, ack every grant → with PRIO_RR_EN: 7, 0, 7, 0; without: 7, 7, 7, 7.
- valid=1, out=4, pending=8'h1C, then rst for 1 cycle with req=0 → after that edge valid=0, out=0, pending=0. No grant until a new req arrives.
